// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target, MSB first, oversampled in the CLK domain.
// Byte-level RX with valid pulse, single-byte TX holding buffer with ready/write handshake.
`timescale 1ns/1ps
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_FILL     = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CS_n,
  output logic       MISO,
  output logic       MISO_OE,
  output logic       SELECTED,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic [7:0] TX_DATA,
  input  logic       TX_WR,
  output logic       TX_READY,
  output logic       TX_UNDERRUN,
  output logic       RX_ABORT
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic [2:0]             cnt_q;
  logic [7:0]             rx_shift_q, rx_data_q;
  logic [7:0]             tx_shift_q, tx_buf_q;
  logic                   tx_ready_q;
  logic                   miso_q, miso_oe_q, selected_q;
  logic                   rx_valid_q, tx_underrun_q, rx_abort_q;

  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic       wr_ok, do_load, load_underrun;
  logic [7:0] load_byte, rx_next;
  logic [2:0] cnt_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;

  // A write landing in the same cycle as a load bypasses the buffer straight into the shifter.
  assign wr_ok         = TX_WR & tx_ready_q;
  assign load_byte     = wr_ok ? TX_DATA : (tx_ready_q ? TX_FILL : tx_buf_q);
  assign load_underrun = ~wr_ok & tx_ready_q;
  assign do_load       = (state_q == IDLE   && cs_fall) ||
                         (state_q == ACTIVE && !cs_rise && sclk_fall && cnt_q == 3'd0);

  assign rx_next  = {rx_shift_q[6:0], mosi_s};
  assign cnt_next = cnt_q + 3'd1;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= IDLE;
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      cs_sync_q     <= '1;
      sclk_dly_q    <= 1'b0;
      cs_dly_q      <= 1'b1;
      cnt_q         <= 3'd0;
      rx_shift_q    <= 8'h00;
      rx_data_q     <= 8'h00;
      tx_shift_q    <= 8'h00;
      tx_buf_q      <= 8'h00;
      tx_ready_q    <= 1'b1;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      selected_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_abort_q    <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
      sclk_dly_q    <= sclk_s;
      cs_dly_q      <= cs_s;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_abort_q    <= 1'b0;

      if (do_load) begin
        tx_ready_q    <= 1'b1;
        tx_underrun_q <= load_underrun;
      end else if (wr_ok) begin
        tx_buf_q   <= TX_DATA;
        tx_ready_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q    <= ACTIVE;
            tx_shift_q <= load_byte;
            miso_q     <= load_byte[7];
            miso_oe_q  <= 1'b1;
            selected_q <= 1'b1;
            cnt_q      <= 3'd0;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            rx_shift_q <= rx_next;
            cnt_q      <= cnt_next;
            if (cnt_q == 3'd7) begin
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
            end
          end else if (sclk_fall && !cs_rise) begin
            if (cnt_q == 3'd0) begin
              tx_shift_q <= load_byte;
              miso_q     <= load_byte[7];
            end else begin
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              miso_q     <= tx_shift_q[6];
            end
          end
          // A completing 8th bit in the same cycle as deselect counts as a full byte.
          if (cs_rise) begin
            state_q    <= IDLE;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            selected_q <= 1'b0;
            cnt_q      <= 3'd0;
            rx_abort_q <= (sclk_rise ? cnt_next : cnt_q) != 3'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO        = miso_q;
  assign MISO_OE     = miso_oe_q;
  assign SELECTED    = selected_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_READY    = tx_ready_q;
  assign TX_UNDERRUN = tx_underrun_q;
  assign RX_ABORT    = rx_abort_q;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - scoreboard bench for spi_target driven by a bit-banged SPI host.
`timescale 1ns/1ps
module tb_spi_target;

  logic       CLK = 1'b0, RESET_n = 1'b0;
  logic       SCLK = 1'b0, MOSI = 1'b0, CS_n = 1'b1, TX_WR = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       MISO, MISO_OE, SELECTED, RX_VALID, TX_READY, TX_UNDERRUN, RX_ABORT;
  logic [7:0] RX_DATA;

  spi_target #(.SYNC_STAGES(2), .TX_FILL(8'hFF)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n),
    .MISO(MISO), .MISO_OE(MISO_OE), .SELECTED(SELECTED),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .TX_DATA(TX_DATA), .TX_WR(TX_WR), .TX_READY(TX_READY),
    .TX_UNDERRUN(TX_UNDERRUN), .RX_ABORT(RX_ABORT)
  );

  always #5 CLK = ~CLK;

  int         vectors = 0, miscompares = 0;
  int         valid_cnt = 0, under_cnt = 0, abort_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] miso_byte = 8'h00;
  int         miso_bits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {MISO, MISO_OE, SELECTED, RX_VALID, TX_READY, TX_UNDERRUN, RX_ABORT, RX_DATA};
  endfunction

  // RX scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (TX_UNDERRUN) under_cnt++;
    if (RX_ABORT) abort_cnt++;
    if (RX_VALID) begin
      valid_cnt++;
      if (exp_rx.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_unexpected: got %0h expected no byte", RX_DATA);
      end else begin
        check("rx_byte", RX_DATA, exp_rx.pop_front());
      end
    end
  end

  // MISO scoreboard: the host's view, sampled at each SCLK rise inside a frame.
  always @(posedge SCLK or posedge CS_n) begin
    if (CS_n) begin
      miso_bits = 0;
    end else begin
      miso_byte = {miso_byte[6:0], MISO};
      miso_bits++;
      if (miso_bits == 8) begin
        miso_bits = 0;
        if (exp_miso.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL miso_unexpected: got %0h expected no byte", miso_byte);
        end else begin
          check("miso_byte", miso_byte, exp_miso.pop_front());
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge CLK);
    TX_DATA = d;
    TX_WR   = 1'b1;
    @(negedge CLK);
    TX_WR   = 1'b0;
  endtask

  task automatic cs_assert();
    @(negedge CLK);
    CS_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_release();
    wait_clk(4);
    CS_n = 1'b1;
    wait_clk(8);
  endtask

  // SCLK = CLK/8: four CLKs low, four high; MOSI changes with the falling edge.
  task automatic xfer(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      wait_clk(4);
      SCLK = 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, u0, a0;
    wait_clk(3);
    check("reset_during", outs(), 15'h0400);
    RESET_n = 1'b1;
    wait_clk(4);
    check("reset_after", outs(), 15'h0400);

    // 1: single byte A5 in, preloaded 3C out
    tx_write(8'h3C);
    check("t1_ready_after_wr", TX_READY, 1'b0);
    v0 = valid_cnt;
    exp_rx.push_back(8'hA5);
    exp_miso.push_back(8'h3C);
    cs_assert();
    check("t1_ready_after_csfall", TX_READY, 1'b1);
    check("t1_sel_oe", {SELECTED, MISO_OE}, 2'b11);
    xfer(8'hA5, 8);
    cs_release();
    check("t1_valid_count", valid_cnt - v0, 1);
    check("t1_idle_outs", {SELECTED, MISO_OE, MISO}, 3'b000);

    // 2: three bytes, only the first has buffer data
    tx_write(8'h11);
    u0 = under_cnt;
    v0 = valid_cnt;
    exp_rx.push_back(8'h01); exp_rx.push_back(8'h02); exp_rx.push_back(8'h03);
    exp_miso.push_back(8'h11); exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
    cs_assert();
    xfer(8'h01, 8);
    xfer(8'h02, 8);
    xfer(8'h03, 8);
    check("t2_underruns", under_cnt - u0, 2);
    cs_release();
    check("t2_valid_count", valid_cnt - v0, 3);

    // 3: aborted frame after 5 bits, then a clean byte
    v0 = valid_cnt;
    a0 = abort_cnt;
    cs_assert();
    xfer(8'hF0, 5);
    cs_release();
    check("t3_abort_count", abort_cnt - a0, 1);
    check("t3_no_valid", valid_cnt - v0, 0);
    check("t3_rx_held", RX_DATA, 8'h03);
    exp_rx.push_back(8'h81);
    exp_miso.push_back(8'hFF);
    cs_assert();
    xfer(8'h81, 8);
    cs_release();
    check("t3_rx_after", RX_DATA, 8'h81);

    // 4: second write while full is dropped
    tx_write(8'h22);
    tx_write(8'h33);
    check("t4_ready_full", TX_READY, 1'b0);
    exp_rx.push_back(8'h44);
    exp_miso.push_back(8'h22);
    cs_assert();
    xfer(8'h44, 8);
    cs_release();
    exp_rx.push_back(8'h55);
    exp_miso.push_back(8'hFF);
    cs_assert();
    xfer(8'h55, 8);
    cs_release();

    // 5: reset mid-byte
    cs_assert();
    xfer(8'hC3, 4);
    @(negedge CLK);
    RESET_n = 1'b0;
    wait_clk(1);
    check("t5_reset_mid", outs(), 15'h0400);
    CS_n = 1'b1;
    wait_clk(4);
    RESET_n = 1'b1;
    wait_clk(4);
    check("t5_reset_released", outs(), 15'h0400);
    exp_rx.push_back(8'h5A);
    exp_miso.push_back(8'hFF);
    cs_assert();
    xfer(8'h5A, 8);
    cs_release();
    check("t5_rx_after", RX_DATA, 8'h5A);

    // 6: 256 back-to-back bytes at max SCLK rate
    v0 = valid_cnt;
    for (int i = 0; i < 256; i++) begin
      exp_rx.push_back(i[7:0]);
      exp_miso.push_back(8'hFF);
    end
    cs_assert();
    for (int i = 0; i < 256; i++) xfer(i[7:0], 8);
    cs_release();
    check("t6_valid_count", valid_cnt - v0, 256);

    check("rx_queue_drained", exp_rx.size(), 0);
    check("miso_queue_drained", exp_miso.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
